// File: rtl/xge_status_pkg.sv
// xge_status_pkg: shared address map, event bit indices and widths
// for the XGE MAC Wishbone status/interrupt controller.
`default_nettype none

package xge_status_pkg;

  localparam int NUM_EVT = 8;
  localparam int NUM_LVL = 2;
  localparam int ISR_W   = NUM_EVT + NUM_LVL;

  localparam logic [7:0] ADDR_ISR      = 8'h00;
  localparam logic [7:0] ADDR_IMR      = 8'h04;
  localparam logic [7:0] ADDR_LVL      = 8'h08;
  localparam logic [7:0] ADDR_CNT_BASE = 8'h10;

  localparam int EVT_PAUSE_FRAME_RX = 0;
  localparam int EVT_RXDFIFO_UDFLOW = 1;
  localparam int EVT_RXDFIFO_OVFLOW = 2;
  localparam int EVT_TXDFIFO_UDFLOW = 3;
  localparam int EVT_TXDFIFO_OVFLOW = 4;
  localparam int EVT_FRAGMENT_ERROR = 5;
  localparam int EVT_CRC_ERROR      = 6;
  localparam int EVT_LENGTH_ERROR   = 7;

  localparam int LVL_REMOTE_FAULT = 0;
  localparam int LVL_LOCAL_FAULT  = 1;

  typedef logic [ISR_W-1:0] isr_t;

endpackage

`default_nettype wire

// File: rtl/status_event_counter.sv
// status_event_counter: saturating event counter with synchronous clear;
// a clear coinciding with an increment leaves the count at 1.
`default_nettype none

module status_event_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? CNT_WIDTH'(1) : '0;
    end else if (inc && (count != {CNT_WIDTH{1'b1}})) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_status_irq_ctrl.sv
// wb_status_irq_ctrl: zero-wait-state Wishbone slave exposing sticky event
// pending bits, an interrupt mask, fault levels and per-event counters.
`default_nettype none

module wb_status_irq_ctrl
  import xge_status_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [7:0]           wb_adr_i,
  input  logic [31:0]          wb_dat_i,
  output logic [31:0]          wb_dat_o,
  input  logic                 wb_we_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_cyc_i,
  output logic                 wb_ack_o,
  output logic                 wb_int_o,
  input  logic [NUM_EVT-1:0]   status_evt,
  input  logic [NUM_LVL-1:0]   status_lvl
);

  isr_t                 isr;
  isr_t                 imr;
  isr_t                 isr_set;
  isr_t                 isr_clr;
  logic [NUM_LVL-1:0]   lvl_q;
  logic [CNT_WIDTH-1:0] cnt [NUM_EVT];
  logic [NUM_EVT-1:0]   cnt_clr;
  logic                 acc;
  logic                 wr;
  logic [5:0]           word;
  logic [5:0]           cnt_off;
  logic [2:0]           cnt_idx;
  logic                 cnt_hit;
  logic                 isr_sel;
  logic                 imr_sel;
  logic                 lvl_sel;
  logic [31:0]          rd_data;
  logic                 unused_bits;

  // The ack gating makes a held strobe produce one access every other cycle.
  assign acc     = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  assign wr      = acc & wb_we_i;
  assign word    = wb_adr_i[7:2];
  assign isr_sel = (word == ADDR_ISR[7:2]);
  assign imr_sel = (word == ADDR_IMR[7:2]);
  assign lvl_sel = (word == ADDR_LVL[7:2]);
  assign cnt_off = word - ADDR_CNT_BASE[7:2];
  assign cnt_hit = (cnt_off < 6'(NUM_EVT));
  assign cnt_idx = cnt_off[2:0];

  assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i[31:ISR_W]};

  assign isr_set = {status_lvl ^ lvl_q, status_evt};
  assign isr_clr = (wr && isr_sel) ? wb_dat_i[ISR_W-1:0] : '0;

  always_comb begin
    rd_data = '0;
    if (isr_sel) begin
      rd_data = 32'(isr);
    end else if (imr_sel) begin
      rd_data = 32'(imr);
    end else if (lvl_sel) begin
      rd_data = 32'(status_lvl);
    end else if (cnt_hit) begin
      rd_data = 32'(cnt[cnt_idx]);
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      wb_int_o <= 1'b0;
      isr      <= '0;
      imr      <= '0;
      lvl_q    <= '0;
    end else begin
      wb_ack_o <= acc;
      wb_dat_o <= acc ? rd_data : '0;
      wb_int_o <= |(isr & imr);
      // New events are ORed in after the clear so a coincident set wins.
      isr      <= (isr & ~isr_clr) | isr_set;
      lvl_q    <= status_lvl;
      if (wr && imr_sel) begin
        imr <= wb_dat_i[ISR_W-1:0];
      end
    end
  end

  for (genvar i = 0; i < NUM_EVT; i++) begin : g_cnt
    assign cnt_clr[i] = wr & cnt_hit & (cnt_idx == 3'(i));

    status_event_counter #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
      .clk   (wb_clk_i),
      .rst   (wb_rst_i),
      .inc   (status_evt[i]),
      .clr   (cnt_clr[i]),
      .count (cnt[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_status_irq_ctrl.sv
// tb_wb_status_irq_ctrl: directed self-checking bench for wb_status_irq_ctrl
// with 4-bit counters so saturation is reachable quickly.
`default_nettype none

module tb_wb_status_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  adr = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic        we = 1'b0;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic        ack;
  logic        irq;
  logic [7:0]  evt = '0;
  logic [1:0]  lvl = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_status_irq_ctrl #(.CNT_WIDTH(4)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wb_adr_i   (adr),
    .wb_dat_i   (dat_i),
    .wb_dat_o   (dat_o),
    .wb_we_i    (we),
    .wb_stb_i   (stb),
    .wb_cyc_i   (cyc),
    .wb_ack_o   (ack),
    .wb_int_o   (irq),
    .status_evt (evt),
    .status_lvl (lvl)
  );

  // Single bus access; ev is driven as a pulse on the same edge that commits it.
  task automatic bus(input logic [7:0] a, input logic w, input logic [31:0] d,
                     input logic [7:0] ev, output logic [31:0] rdata);
    @(negedge clk);
    adr = a; we = w; dat_i = d; stb = 1'b1; cyc = 1'b1; evt = ev;
    @(posedge clk); #1;
    rdata = dat_o;
    checks++;
    if (ack !== 1'b1) begin
      errors++;
      $display("FAIL ack_high adr=%02h got=%b exp=1", a, ack);
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0; evt = '0;
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b0 || dat_o !== 32'h0) begin
      errors++;
      $display("FAIL ack_one_cycle adr=%02h ack=%b dat=%08h exp ack=0 dat=0", a, ack, dat_o);
    end
  endtask

  task automatic rd_expect(input logic [7:0] a, input logic [31:0] exp, input string name);
    logic [31:0] r;
    bus(a, 1'b0, 32'h0, 8'h0, r);
    checks++;
    if (r !== exp) begin
      errors++;
      $display("FAIL %s adr=%02h got=%08h exp=%08h", name, a, r, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [7:0] ev);
    logic [31:0] r;
    bus(a, 1'b1, d, ev, r);
  endtask

  task automatic pulse(input logic [7:0] ev);
    @(negedge clk); evt = ev;
    @(negedge clk); evt = '0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ack !== 1'b0 || dat_o !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs ack=%b dat=%08h int=%b exp 0,0,0", ack, dat_o, irq);
    end
    @(negedge clk); rst = 1'b0;
    rd_expect(8'h00, 32'h0, "reset_isr");
    rd_expect(8'h04, 32'h0, "reset_imr");
    rd_expect(8'h08, 32'h0, "reset_lvl");
    for (int i = 0; i < 8; i++) rd_expect(8'(8'h10 + 4 * i), 32'h0, "reset_cnt");
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_int got=%b exp=0", irq);
    end
  endtask

  task automatic test_irq();
    wr(8'h04, 32'h040, 8'h0);
    @(negedge clk); evt = 8'h40;
    @(posedge clk); #1;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL int_latency_early got=%b exp=0", irq);
    end
    evt = '0;
    @(posedge clk); #1;
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL int_assert got=%b exp=1", irq);
    end
    rd_expect(8'h00, 32'h040, "isr_evt6");
    rd_expect(8'h28, 32'h1, "cnt6_one");
    wr(8'h00, 32'h040, 8'h0);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL int_after_w1c got=%b exp=0", irq);
    end
    rd_expect(8'h00, 32'h0, "isr_cleared");
  endtask

  task automatic test_counter();
    for (int i = 0; i < 20; i++) pulse(8'h01);
    rd_expect(8'h10, 32'd15, "cnt0_saturate");
    wr(8'h10, 32'h0, 8'h01);
    rd_expect(8'h10, 32'd1, "cnt0_clear_inc");
    wr(8'h10, 32'h0, 8'h00);
    rd_expect(8'h10, 32'd0, "cnt0_clear");
    rd_expect(8'h00, 32'h001, "isr_evt0");
  endtask

  task automatic test_lvl();
    wr(8'h00, 32'h3FF, 8'h0);
    wr(8'h04, 32'h0, 8'h0);
    @(negedge clk); lvl = 2'b10;
    repeat (3) @(negedge clk);
    lvl = 2'b00;
    repeat (3) @(negedge clk);
    rd_expect(8'h00, 32'h200, "isr_lvl1");
    rd_expect(8'h08, 32'h0, "lvl_read");
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL int_masked got=%b exp=0", irq);
    end
    wr(8'h04, 32'h200, 8'h0);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL int_imr9 got=%b exp=1", irq);
    end
    @(negedge clk); lvl = 2'b01;
    repeat (2) @(negedge clk);
    rd_expect(8'h08, 32'h1, "lvl_read_remote");
    @(negedge clk); lvl = 2'b00;
    repeat (2) @(negedge clk);
    rd_expect(8'h00, 32'h300, "isr_lvl_both");
  endtask

  task automatic test_w1c_race();
    wr(8'h00, 32'h3FF, 8'h0);
    wr(8'h04, 32'h0, 8'h0);
    wr(8'h00, 32'h004, 8'h04);
    rd_expect(8'h00, 32'h004, "isr_set_wins");
    rd_expect(8'h18, 32'h1, "cnt2_one");
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_pat;
    logic [5:0] got_pat;
    exp_pat = 6'b101010;
    got_pat = '0;
    @(negedge clk);
    adr = 8'h3C; we = 1'b0; stb = 1'b1; cyc = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      got_pat[5 - i] = ack;
      checks++;
      if (dat_o !== 32'h0) begin
        errors++;
        $display("FAIL b2b_data cycle=%0d got=%08h exp=0", i, dat_o);
      end
    end
    stb = 1'b0; cyc = 1'b0;
    checks++;
    if (got_pat !== exp_pat) begin
      errors++;
      $display("FAIL b2b_ack_pattern got=%b exp=%b", got_pat, exp_pat);
    end
    wr(8'h04, 32'h155, 8'h0);
    wr(8'h3C, 32'hFFFF_FFFF, 8'h0);
    rd_expect(8'h04, 32'h155, "imr_after_unmapped");
    rd_expect(8'h00, 32'h004, "isr_after_unmapped");
    rd_expect(8'h3C, 32'h0, "unmapped_read");
  endtask

  initial begin
    test_reset();
    test_irq();
    test_counter();
    test_lvl();
    test_w1c_race();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
